// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the fetch buffer: instruction encodings, reset
// defaults and the entry format held in the instruction FIFO.
`ifndef FETCH_BUFFER_PKG_SV
`define FETCH_BUFFER_PKG_SV

package fetch_buffer_pkg;

    // Canonical NOP (addi x0, x0, 0) presented when no instruction is valid.
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Default first fetch address after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Byte distance between consecutive instruction words.
    localparam logic [31:0] INST_BYTES = 32'd4;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

`endif

// File: rtl/fetch_buffer_fifo_sync.sv
// Synchronous circular FIFO with a combinational head. Depth must be a power
// of two so that the read/write pointers wrap naturally. A push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module fifo_sync #(
    parameter int unsigned width = 32,
    parameter int unsigned depth = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [width-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [$clog2(depth):0]   count,
    output logic [width-1:0]         head
);

    localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CW = $clog2(depth) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    // Next-state for storage, pointers and occupancy; clear wins over traffic.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != FULL_COUNT) || pop_ok);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer. Issues word fetches to instruction memory under a
// credit limit (buffered + in-flight never exceeds depth), queues responses
// with their PCs and presents the head to decode. A redirect clears the
// buffer, retargets fetch and marks every in-flight response for discard.
//
// Handshakes: a fetch is accepted when imem_req && imem_gnt in the same cycle;
// memory returns exactly one imem_rvalid pulse per accepted fetch, in order,
// no earlier than the following cycle. The head is consumed when
// out_valid && !pause && !jump.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter logic [31:0] reset_pc = DEFAULT_RESET_PC,
    parameter int unsigned depth    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        jump,
    input  logic [31:0] jump_addr,
    input  logic        pause,
    output logic        out_valid,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int unsigned CW = $clog2(depth) + 1;
    localparam logic [CW:0] CREDIT = (CW + 1)'(depth);

    logic [31:0]   fpc_q, fpc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic [CW-1:0] osd_q, osd_d;
    logic [CW-1:0] drp_q, drp_d;
    logic [CW-1:0] cnt;
    logic [CW:0]   in_use;
    logic          handshake;
    logic          rsp_valid;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Credit check and request generation; a redirect suppresses the request.
    always_comb begin
        in_use    = {1'b0, cnt} + {1'b0, osd_q};
        imem_req  = !rst && !jump && (in_use < CREDIT);
        imem_addr = fpc_q;
        handshake = imem_req && imem_gnt;
        rsp_valid = imem_rvalid && !rst;
    end

    // Next-state for fetch/response PCs, outstanding and drop counters, and
    // the FIFO push/pop strobes. A redirect overrides every other update.
    always_comb begin
        fpc_d      = fpc_q;
        rpc_d      = rpc_q;
        osd_d      = osd_q;
        drp_d      = drp_q;
        push       = 1'b0;
        pop        = 1'b0;
        push_entry = '{pc: rpc_q, inst: imem_rdata};
        if (jump) begin
            fpc_d = align_word(jump_addr);
            rpc_d = align_word(jump_addr);
            // Every response still owed, except one landing right now, is stale.
            osd_d = osd_q - CW'(rsp_valid);
            drp_d = osd_q - CW'(rsp_valid);
        end else begin
            if (handshake) begin
                fpc_d = fpc_q + INST_BYTES;
            end
            osd_d = osd_q + CW'(handshake) - CW'(rsp_valid);
            if (rsp_valid) begin
                if (drp_q != '0) begin
                    drp_d = drp_q - CW'(1);
                end else begin
                    push  = 1'b1;
                    rpc_d = rpc_q + INST_BYTES;
                end
            end
            pop = out_valid && !pause;
        end
    end

    // Architectural state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q <= reset_pc;
            rpc_q <= reset_pc;
            osd_q <= '0;
            drp_q <= '0;
        end else begin
            fpc_q <= fpc_d;
            rpc_q <= rpc_d;
            osd_q <= osd_d;
            drp_q <= drp_d;
        end
    end

    fifo_sync #(
        .width ($bits(fetch_entry_t)),
        .depth (depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (jump),
        .count     (cnt),
        .head      (head_entry)
    );

    // Head presentation; an empty buffer shows a NOP at PC 0.
    always_comb begin
        out_valid = (cnt != '0);
        out_inst  = out_valid ? head_entry.inst : NOP_INST;
        out_pc    = out_valid ? head_entry.pc : 32'h0000_0000;
    end

endmodule
